// File: rtl/mac_dot_seq.sv
// rtl/mac_dot_seq.sv - signed 8-bit dot-product sequencer driving one mac_unit lane
//
// On a host command this block clears the MAC accumulator, streams len operand pairs
// from two synchronous-read buffers through the MAC one at a time, and returns the
// final accumulator on a valid/ready result port. A MAC that stops answering is
// bounded by a per-element timeout that aborts the command with result_err set.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   start, len, base_a, base_b host command (sampled only while idle)
//   busy                       high whenever a command is in flight
//   rd_en, rd_addr_a/b         read request to both operand buffers
//   rd_data_a/b                signed buffer data, valid the cycle after rd_en
//   mac_clr                    one-cycle accumulator clear (MAC reset = reset | mac_clr)
//   mac_valid, mac_a, mac_b    operand handoff to the MAC
//   mac_done, mac_y            MAC completion pulse and signed accumulator
//   result_valid/ready         result handshake
//   result, result_err         signed dot product; err=1 marks a timeout abort

module mac_dot_seq #(
  parameter int ADDR_W  = 8,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  input  logic [ADDR_W-1:0]        base_a,
  input  logic [ADDR_W-1:0]        base_b,
  output logic                     busy,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr_a,
  output logic [ADDR_W-1:0]        rd_addr_b,
  input  logic signed [7:0]        rd_data_a,
  input  logic signed [7:0]        rd_data_b,
  output logic                     mac_clr,
  output logic                     mac_valid,
  output logic signed [7:0]        mac_a,
  output logic signed [7:0]        mac_b,
  input  logic                     mac_done,
  input  logic signed [31:0]       mac_y,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic signed [31:0]       result,
  output logic                     result_err
);

  // Wide enough to hold TIMEOUT itself, so the increment on the final WAIT
  // cycle never wraps before the state machine leaves WAIT.
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_ISSUE,
    S_VALID,
    S_WAIT,
    S_RESULT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  cnt_inc;
  logic [ADDR_W-1:0] base_a_q;
  logic [ADDR_W-1:0] base_b_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              last_elem;
  logic              wait_expired;

  // len_q is never zero once a command is running, so len_q-1 cannot underflow.
  assign last_elem    = (cnt == len_q - LEN_W'(1));
  assign cnt_inc      = cnt + LEN_W'(1);
  // wait_cnt is 0 on the first WAIT cycle, so TIMEOUT-1 marks the last allowed one.
  assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT - 1));

  assign busy = (state != S_IDLE);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and state-decoded strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    rd_en        = 1'b0;
    mac_clr      = 1'b0;
    mac_valid    = 1'b0;
    result_valid = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_nxt = S_CLEAR;
          end else begin
            state_nxt = S_RESULT;
          end
        end
      end

      S_CLEAR: begin
        mac_clr   = 1'b1;
        state_nxt = S_FETCH;
      end

      S_FETCH: begin
        rd_en     = 1'b1;
        state_nxt = S_ISSUE;
      end

      S_ISSUE: begin
        state_nxt = S_VALID;
      end

      S_VALID: begin
        mac_valid = 1'b1;
        state_nxt = S_WAIT;
      end

      S_WAIT: begin
        // A done on the final allowed cycle still wins over the timeout.
        if (mac_done) begin
          if (last_elem) begin
            state_nxt = S_RESULT;
          end else begin
            state_nxt = S_FETCH;
          end
        end else if (wait_expired) begin
          state_nxt = S_RESULT;
        end
      end

      S_RESULT: begin
        result_valid = 1'b1;
        if (result_ready) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: command latch, counters, registered addresses/operands/result
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q      <= '0;
      cnt        <= '0;
      base_a_q   <= '0;
      base_b_q   <= '0;
      wait_cnt   <= '0;
      rd_addr_a  <= '0;
      rd_addr_b  <= '0;
      mac_a      <= '0;
      mac_b      <= '0;
      result     <= '0;
      result_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q    <= len;
            base_a_q <= base_a;
            base_b_q <= base_b;
            cnt      <= '0;
            if (len == '0) begin
              result     <= '0;
              result_err <= 1'b0;
            end
          end
        end

        // Addresses are registered, so they are loaded on the edge that enters
        // FETCH: here for element 0, and in WAIT for every later element.
        S_CLEAR: begin
          rd_addr_a <= base_a_q + ADDR_W'(cnt);
          rd_addr_b <= base_b_q + ADDR_W'(cnt);
        end

        S_ISSUE: begin
          mac_a <= rd_data_a;
          mac_b <= rd_data_b;
        end

        S_VALID: begin
          wait_cnt <= '0;
        end

        S_WAIT: begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
          if (mac_done) begin
            if (last_elem) begin
              result     <= mac_y;
              result_err <= 1'b0;
            end else begin
              cnt       <= cnt_inc;
              rd_addr_a <= base_a_q + ADDR_W'(cnt_inc);
              rd_addr_b <= base_b_q + ADDR_W'(cnt_inc);
            end
          end else if (wait_expired) begin
            result     <= '0;
            result_err <= 1'b1;
          end
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/mac_dot_seq.md
# mac_dot_seq

Sequencer for one `mac_unit`: on a host command it runs a signed 8-bit dot product of length `len` through the MAC.
- Clears the MAC accumulator first.
- Fetches operand pairs from two synchronous-read operand buffers.
- Handshakes each pair into the MAC (`valid` in, `done` back).
- Returns the final 32-bit accumulator value on a valid/ready result port.

Sits between the host/array scheduler and a single MAC lane.

## Interface
Parameters:
- `ADDR_W`, 8: operand buffer address width.
- `LEN_W`, 8: width of the `len` command field.
- `TIMEOUT`, 15: maximum WAIT cycles for `mac_done` before error abort.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `start` in 1: command strobe, sampled only in IDLE.
- `len` in LEN_W: number of element pairs, unsigned.
- `base_a`, `base_b` in ADDR_W: first address in buffer A and buffer B.
- `busy` out 1: high whenever state is not IDLE.
- `rd_en` out 1: read strobe to both buffers.
- `rd_addr_a`, `rd_addr_b` out ADDR_W: buffer read addresses.
- `rd_data_a`, `rd_data_b` in 8: signed read data, valid the cycle after `rd_en`.
- `mac_clr` out 1: accumulator clear pulse. Integration drives MAC `reset` = `reset | mac_clr`.
- `mac_valid` out 1: MAC start strobe.
- `mac_a`, `mac_b` out 8: signed operands, registered.
- `mac_done` in 1: MAC completion pulse.
- `mac_y` in 32: signed MAC accumulator.
- `result_valid` out 1: result available.
- `result_ready` in 1: host accepts result.
- `result` out 32: signed dot product.
- `result_err` out 1: qualifies `result`; 1 means timeout abort.

## Operation
- States: IDLE, CLEAR, FETCH, ISSUE, VALID, WAIT, RESULT.
- **IDLE**
  - `start` with `len != 0`: latch `len`, `base_a`, `base_b`; clear element counter `cnt`; go to CLEAR.
  - `start` with `len == 0`: go to RESULT with `result = 0`, `result_err = 0`.
  - `start` in any other state is ignored.
- **CLEAR**: `mac_clr = 1` for exactly one cycle; go to FETCH.
- **FETCH**: `rd_en = 1`, `rd_addr_a = base_a + cnt`, `rd_addr_b = base_b + cnt`, modulo 2^ADDR_W (wraps, no error); go to ISSUE.
- **ISSUE**: register `rd_data_a`/`rd_data_b` into `mac_a`/`mac_b`; go to VALID.
- **VALID**: `mac_valid = 1` for one cycle; go to WAIT. `mac_a`/`mac_b` hold their values until the next ISSUE.
- **WAIT**: a wait counter increments each cycle.
  - On `mac_done` with `cnt == len-1`: capture `mac_y` into `result`, `result_err = 0`; go to RESULT.
  - On `mac_done` otherwise: `cnt++`, go to FETCH.
  - If the wait counter reaches TIMEOUT with no `mac_done`: `result = 0`, `result_err = 1`; go to RESULT.
  - The wait counter clears on entry to WAIT.
- **RESULT**: `result_valid = 1`; `result` and `result_err` are stable. When `result_valid && result_ready`, go to IDLE.
- **Arithmetic**
  - `result` is `mac_y` taken verbatim; 32-bit two's complement overflow wraps inside the MAC and is not flagged.
  - `cnt` is LEN_W bits wide and never exceeds `len-1`.
- `mac_done` outside WAIT is ignored.
- **`reset` high at any rising edge, including mid-sequence**
  - State goes to IDLE; all counters clear.
  - All outputs go to 0: `busy`, `rd_en`, `rd_addr_*`, `mac_clr`, `mac_valid`, `mac_a`, `mac_b`, `result_valid`, `result`, `result_err`.
  - The MAC is reset through the shared `reset`.

## Timing
- `start` accepted at edge s → CLEAR cycle s+1 → first FETCH s+2.
- Each element takes 6 cycles: FETCH, ISSUE, VALID, then 3 WAIT cycles. `mac_done` is seen on the third WAIT cycle, following the MAC's LOAD, PROCESSING, DONE states.
- `result_valid` first rises in cycle s+2+6·len. For `len = 0`, it rises in cycle s+1.
- `busy` rises the cycle after `start` and falls the cycle after the `result_valid && result_ready` handshake.
- A new `start` is accepted in that first IDLE cycle, so back-to-back commands run with 1 idle cycle between them.
- Every output is registered except `busy`, `rd_en`, `mac_clr`, `mac_valid` and `result_valid`, which are decoded from state.

## Test plan
- **Single element**: `len=1`, A[0]=3, B[0]=-4 → `result_valid` at s+8, `result=-12`, `result_err=0`, exactly one `mac_clr` pulse and one `mac_valid` pulse.
- **Four elements with backpressure**: `len=4`, A={1,2,3,4}, B={5,6,7,8} → `result=70` at s+26; hold `result_ready=0` for 5 cycles → `result` stable and `busy=1` throughout.
- **Extremes and wrap**: `len=2`, A={-128,-128}, B={-128,127}, `base_a=255` → `rd_addr_a` reads 255 then 0, `result=16384-16256=128`.
- **Zero length and back-to-back**: `len=0` → `result=0` at s+1. Then run two `len=3` commands whose individual sums are 10 and 20 → results are 10 and 20, confirming the accumulator is cleared between commands.
- **Timeout**: MAC model withholds `mac_done` → after 15 WAIT cycles, `result_err=1`, `result=0`. `start` pulses while `busy` are ignored.
- **Reset mid-run**: `len=4`, assert `reset` during the second WAIT → next cycle all outputs are 0 and state is IDLE. A following `len=1` command (A[0]=3, B[0]=-4) gives `result=-12`.
